// File: rtl/msg_comm_pkg.sv
// Shared definitions for the message link: FSM encodings and the CRC-8 used by TX and RX.
package msg_comm_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;
  localparam logic [BYTE_W-1:0] CRC8_INIT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX    = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  // Byte-parallel CRC-8 update, MSB first, non-reflected
  function automatic logic [BYTE_W-1:0] next_crc8_d8(input logic [BYTE_W-1:0] data,
                                                      input logic [BYTE_W-1:0] crc);
    logic [BYTE_W-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/message_comm_rx_if.sv
// Serial link inputs and decoded payload/status outputs of the message receiver.
interface message_comm_rx_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 MSG_RX_FSX;
  logic                 MSG_RX;
  logic [7:0]           msg_rx_data_o;
  logic                 msg_rx_data_vld_o;
  logic [CNT_WIDTH-1:0] msg_rx_byte_num_o;
  logic                 msg_rx_done_o;
  logic                 msg_rx_crc_err_o;
  logic                 msg_rx_ovf_o;

  // Link/transmitter side
  modport master (
    output MSG_RX_FSX, MSG_RX,
    input  msg_rx_data_o, msg_rx_data_vld_o, msg_rx_byte_num_o,
           msg_rx_done_o, msg_rx_crc_err_o, msg_rx_ovf_o
  );

  // Receiver side
  modport slave (
    input  MSG_RX_FSX, MSG_RX,
    output msg_rx_data_o, msg_rx_data_vld_o, msg_rx_byte_num_o,
           msg_rx_done_o, msg_rx_crc_err_o, msg_rx_ovf_o
  );
endinterface

// File: rtl/message_comm_rx_deser.sv
// Input registers, FSX edge detect and MSB-first byte assembly for the message receiver.
module msg_rx_deser
  import msg_comm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fsx_in,
  input  logic              bit_in,
  input  logic              start_c,
  input  logic              shift_c,
  output logic              fsx_r,
  output logic              rise_c,
  output logic              byte_vld,
  output logic [BYTE_W-1:0] byte_q
);

  logic              fsx_r_d;
  logic              bit_r;
  logic [BYTE_W-1:0] shreg;
  logic [2:0]        bit_cnt;

  // FSX regs reset high so a strobe already asserted at reset release needs a real low first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsx_r   <= 1'b1;
      fsx_r_d <= 1'b1;
      bit_r   <= 1'b0;
    end else begin
      fsx_r   <= fsx_in;
      fsx_r_d <= fsx_r;
      bit_r   <= bit_in;
    end
  end

  assign rise_c = fsx_r & ~fsx_r_d;

  // Shift register and 3-bit wrapping counter; registered strobe when the 8th bit lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_vld <= 1'b0;
      if (start_c) begin
        shreg   <= {7'b0, bit_r};
        bit_cnt <= 3'd1;
      end else if (shift_c) begin
        shreg   <= {shreg[6:0], bit_r};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_q   <= {shreg[6:0], bit_r};
        end
      end
    end
  end

endmodule

// File: rtl/message_comm_rx.sv
// Message link receiver: frames bytes, holds back the trailing CRC byte and checks it.
module message_comm_rx
  import msg_comm_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 1024,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  message_comm_rx_if.slave bus
);

  rx_state_t            state, state_nxt;
  logic [BYTE_W-1:0]    crc, crc_nxt;
  logic [BYTE_W-1:0]    hold, hold_nxt;
  logic                 hold_vld, hold_vld_nxt;
  logic [CNT_WIDTH-1:0] byte_cnt, cnt_nxt;
  logic                 ovf_flag, ovf_flag_nxt;
  logic [BYTE_W-1:0]    data_q, data_nxt;
  logic                 vld_q, vld_nxt;
  logic                 done_q, done_nxt;
  logic [CNT_WIDTH-1:0] num_q, num_nxt;
  logic                 err_q, err_nxt;
  logic                 ovf_q, ovf_nxt;

  logic                 start_c, shift_c;
  logic                 fsx_r, rise_c, byte_vld;
  logic [BYTE_W-1:0]    byte_q;

  msg_rx_deser u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .fsx_in   (bus.MSG_RX_FSX),
    .bit_in   (bus.MSG_RX),
    .start_c  (start_c),
    .shift_c  (shift_c),
    .fsx_r    (fsx_r),
    .rise_c   (rise_c),
    .byte_vld (byte_vld),
    .byte_q   (byte_q)
  );

  // Framing FSM: hold buffer, CRC accumulation, overflow and end-of-frame status
  always_comb begin
    state_nxt    = state;
    crc_nxt      = crc;
    hold_nxt     = hold;
    hold_vld_nxt = hold_vld;
    cnt_nxt      = byte_cnt;
    ovf_flag_nxt = ovf_flag;
    data_nxt     = data_q;
    vld_nxt      = 1'b0;
    done_nxt     = 1'b0;
    num_nxt      = num_q;
    err_nxt      = err_q;
    ovf_nxt      = ovf_q;
    start_c      = 1'b0;
    shift_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          start_c   = 1'b1;
          state_nxt = ST_RX;
        end
      end
      ST_RX: begin
        shift_c = fsx_r;
        if (byte_vld) begin
          if (hold_vld) begin
            if (byte_cnt == CNT_WIDTH'(MAX_BYTES)) begin
              ovf_flag_nxt = 1'b1;
            end else begin
              data_nxt = hold;
              vld_nxt  = 1'b1;
              crc_nxt  = next_crc8_d8(hold, crc);
              cnt_nxt  = byte_cnt + CNT_WIDTH'(1);
            end
          end
          hold_nxt     = byte_q;
          hold_vld_nxt = 1'b1;
        end
        if (!fsx_r) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        done_nxt  = 1'b1;
        num_nxt   = byte_cnt;
        err_nxt   = ~hold_vld | (hold != crc) | ovf_flag;
        ovf_nxt   = ovf_flag;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        crc_nxt      = CRC8_INIT;
        hold_vld_nxt = 1'b0;
        cnt_nxt      = '0;
        ovf_flag_nxt = 1'b0;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      crc      <= CRC8_INIT;
      hold     <= '0;
      hold_vld <= 1'b0;
      byte_cnt <= '0;
      ovf_flag <= 1'b0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      num_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      crc      <= crc_nxt;
      hold     <= hold_nxt;
      hold_vld <= hold_vld_nxt;
      byte_cnt <= cnt_nxt;
      ovf_flag <= ovf_flag_nxt;
      data_q   <= data_nxt;
      vld_q    <= vld_nxt;
      done_q   <= done_nxt;
      num_q    <= num_nxt;
      err_q    <= err_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  assign bus.msg_rx_data_o     = data_q;
  assign bus.msg_rx_data_vld_o = vld_q;
  assign bus.msg_rx_byte_num_o = $bits(bus.msg_rx_byte_num_o)'(num_q);
  assign bus.msg_rx_done_o     = done_q;
  assign bus.msg_rx_crc_err_o  = err_q;
  assign bus.msg_rx_ovf_o      = ovf_q;

endmodule

// File: tb/tb_message_comm_rx.sv
// Directed bench for message_comm_rx (MAX_BYTES=4 so overflow is reachable).
module tb_message_comm_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_num = 0;
  logic last_err = 1'b0;
  logic last_ovf = 1'b0;
  logic [7:0] vld_q[$];
  int   vld_cyc[$];
  logic [7:0] frame_b[0:15];
  int   prev_done;

  message_comm_rx_if #(.CNT_WIDTH(16)) bus ();

  message_comm_rx #(.MAX_BYTES(4), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record payload strobes and end-of-frame status away from the active edge
  always @(negedge clk) begin
    if (bus.msg_rx_data_vld_o) begin
      vld_q.push_back(bus.msg_rx_data_o);
      vld_cyc.push_back(cyc);
    end
    if (bus.msg_rx_done_o) begin
      done_cnt = done_cnt + 1;
      last_num = int'(bus.msg_rx_byte_num_o);
      last_err = bus.msg_rx_crc_err_o;
      last_ovf = bus.msg_rx_ovf_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-8 over frame_b[0..n-1]
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    logic fb;
    c = 8'hFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ frame_b[i][b];
        c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic send_frame(input int nbytes, input int extra_bits);
    for (int i = 0; i < nbytes; i++) begin
      for (int b = 7; b >= 0; b--) begin
        @(negedge clk);
        bus.MSG_RX_FSX = 1'b1;
        bus.MSG_RX     = frame_b[i][b];
      end
    end
    for (int j = 0; j < extra_bits; j++) begin
      @(negedge clk);
      bus.MSG_RX_FSX = 1'b1;
      bus.MSG_RX     = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.MSG_RX_FSX = 1'b0;
    bus.MSG_RX     = 1'b0;
  endtask

  task automatic start_capture();
    vld_q.delete();
    vld_cyc.delete();
    prev_done = done_cnt;
  endtask

  task automatic wait_done(input string tag);
    repeat (30) @(posedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt - prev_done), 32'd1);
  endtask

  initial begin
    bus.MSG_RX_FSX = 1'b0;
    bus.MSG_RX     = 1'b0;
    #1;
    chk("rst_vld", 32'(bus.msg_rx_data_vld_o), 32'd0);
    chk("rst_done", 32'(bus.msg_rx_done_o), 32'd0);
    chk("rst_num", 32'(bus.msg_rx_byte_num_o), 32'd0);
    chk("rst_err", 32'(bus.msg_rx_crc_err_o), 32'd0);
    chk("rst_ovf", 32'(bus.msg_rx_ovf_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single 0x00 byte, CRC 0xF3
    start_capture();
    frame_b[0] = 8'h00;
    frame_b[1] = 8'hF3;
    send_frame(2, 0);
    wait_done("f00");
    chk("f00_nvld", 32'(vld_q.size()), 32'd1);
    if (vld_q.size() > 0) chk("f00_data", 32'(vld_q[0]), 32'h00);
    chk("f00_num", 32'(last_num), 32'd1);
    chk("f00_err", 32'(last_err), 32'd0);
    chk("f00_ovf", 32'(last_ovf), 32'd0);

    // Three payload bytes, good CRC; FSX held one extra bit
    start_capture();
    frame_b[0] = 8'hA5;
    frame_b[1] = 8'h3C;
    frame_b[2] = 8'hFF;
    frame_b[3] = ref_crc(3);
    send_frame(4, 1);
    wait_done("f3");
    chk("f3_nvld", 32'(vld_q.size()), 32'd3);
    if (vld_q.size() == 3) begin
      chk("f3_d0", 32'(vld_q[0]), 32'hA5);
      chk("f3_d1", 32'(vld_q[1]), 32'h3C);
      chk("f3_d2", 32'(vld_q[2]), 32'hFF);
      chk("f3_gap01", 32'(vld_cyc[1] - vld_cyc[0]), 32'd8);
      chk("f3_gap12", 32'(vld_cyc[2] - vld_cyc[1]), 32'd8);
    end
    chk("f3_num", 32'(last_num), 32'd3);
    chk("f3_err", 32'(last_err), 32'd0);
    chk("f3_ovf", 32'(last_ovf), 32'd0);

    // Same frame with CRC bit0 flipped
    start_capture();
    frame_b[3] = ref_crc(3) ^ 8'h01;
    send_frame(4, 0);
    wait_done("fbad");
    chk("fbad_nvld", 32'(vld_q.size()), 32'd3);
    if (vld_q.size() == 3) chk("fbad_d2", 32'(vld_q[2]), 32'hFF);
    chk("fbad_num", 32'(last_num), 32'd3);
    chk("fbad_err", 32'(last_err), 32'd1);

    // Zero payload: only CRC 0xFF
    start_capture();
    frame_b[0] = 8'hFF;
    send_frame(1, 0);
    wait_done("fz");
    chk("fz_nvld", 32'(vld_q.size()), 32'd0);
    chk("fz_num", 32'(last_num), 32'd0);
    chk("fz_err", 32'(last_err), 32'd0);

    // 5-bit runt
    start_capture();
    send_frame(0, 5);
    wait_done("runt");
    chk("runt_nvld", 32'(vld_q.size()), 32'd0);
    chk("runt_num", 32'(last_num), 32'd0);
    chk("runt_err", 32'(last_err), 32'd1);

    // Six payload bytes against MAX_BYTES=4
    start_capture();
    for (int i = 0; i < 6; i++) frame_b[i] = 8'(i + 1);
    frame_b[6] = ref_crc(6);
    send_frame(7, 0);
    wait_done("ovf");
    chk("ovf_nvld", 32'(vld_q.size()), 32'd4);
    if (vld_q.size() == 4) chk("ovf_d3", 32'(vld_q[3]), 32'h04);
    chk("ovf_num", 32'(last_num), 32'd4);
    chk("ovf_ovf", 32'(last_ovf), 32'd1);
    chk("ovf_err", 32'(last_err), 32'd1);

    // Reset mid-byte with FSX held high, then a clean frame
    start_capture();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.MSG_RX_FSX = 1'b1;
      bus.MSG_RX     = 1'($urandom_range(0, 1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_num", 32'(bus.msg_rx_byte_num_o), 32'd0);
    chk("mrst_err", 32'(bus.msg_rx_crc_err_o), 32'd0);
    chk("mrst_ovf", 32'(bus.msg_rx_ovf_o), 32'd0);
    chk("mrst_done", 32'(bus.msg_rx_done_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.MSG_RX_FSX = 1'b1;
      bus.MSG_RX     = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.MSG_RX_FSX = 1'b0;
    repeat (30) @(posedge clk);
    chk("mrst_no_done", 32'(done_cnt - prev_done), 32'd0);
    chk("mrst_no_vld", 32'(vld_q.size()), 32'd0);

    start_capture();
    frame_b[0] = 8'h12;
    frame_b[1] = ref_crc(1);
    send_frame(2, 0);
    wait_done("f12");
    chk("f12_nvld", 32'(vld_q.size()), 32'd1);
    if (vld_q.size() > 0) chk("f12_data", 32'(vld_q[0]), 32'h12);
    chk("f12_num", 32'(last_num), 32'd1);
    chk("f12_err", 32'(last_err), 32'd0);
    chk("f12_ovf", 32'(last_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
